// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU memory path.
// Holds the sequencer state encoding and the memory geometry defaults.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WORD_BYTES        = 4;
    localparam int DEFAULT_MEM_WORDS = 64;

    function automatic logic [29:0] word_index(input logic [31:0] adr);
        return adr[31:2];
    endfunction

endpackage

// File: rtl/addr_check.sv
// Combinational legality check for a single memory request: misalignment,
// out-of-range word index and the illegal store-fetch combination.
module addr_check
    import cpu_pkg::*;
#(
    parameter int ADDR_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic [31:0] i_adr,
    input  logic        i_we,
    input  logic        i_fetch,
    output logic        o_misalign,
    output logic        o_range,
    output logic        o_conflict,
    output logic        o_err
);

    // Full 30-bit unsigned compare so high addresses never alias into memory.
    assign o_misalign = (i_adr[1:0] != 2'b00);
    assign o_range    = (word_index(i_adr) >= 30'(ADDR_WORDS));
    assign o_conflict = i_we & i_fetch;
    assign o_err      = o_misalign | o_range | o_conflict;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side access sequencer: one fetch/load/store at a time, programmable
// wait states, read data captured into instr/old_pc or data.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_WORDS  = DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_fetch,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] instr,
    output logic [31:0] old_pc,
    output logic [31:0] data,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_fetch;
    logic        r_err;
    logic [31:0] r_instr;
    logic [31:0] r_old_pc;
    logic [31:0] r_data;

    logic        w_misalign;
    logic        w_range;
    logic        w_conflict;
    logic        w_err;

    addr_check #(
        .ADDR_WORDS (ADDR_WORDS)
    ) u_addr_check (
        .i_adr      (req_adr),
        .i_we       (req_we),
        .i_fetch    (req_fetch),
        .o_misalign (w_misalign),
        .o_range    (w_range),
        .o_conflict (w_conflict),
        .o_err      (w_err)
    );

    // Sequencer FSM: accept, count wait states, capture read data, respond.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_adr    <= 32'd0;
            r_wdata  <= 32'd0;
            r_we     <= 1'b0;
            r_fetch  <= 1'b0;
            r_err    <= 1'b0;
            r_instr  <= 32'd0;
            r_old_pc <= 32'd0;
            r_data   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_adr   <= req_adr;
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_fetch <= req_fetch;
                        r_err   <= w_err;
                        if (w_err) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ACCESS;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            if (r_fetch) begin
                                r_instr  <= mem_rdata;
                                r_old_pc <= r_adr;
                            end else begin
                                r_data <= mem_rdata;
                            end
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so an asserted reset kills a pending write.
    assign mem_we     = (r_state == ACCESS) && (r_cnt == 4'd0) && r_we;
    assign mem_adr    = r_adr;
    assign mem_wdata  = r_wdata;
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign resp_err   = (r_state == DONE) && r_err;
    assign instr      = r_instr;
    assign old_pc     = r_old_pc;
    assign data       = r_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a behavioural
// memory/register model; includes directed boundary and mid-store reset cases.
module tb_mem_access_ctrl;

    localparam int W  = 2;
    localparam int AW = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_fetch;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] data;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:AW-1];
    logic        tb_wr_en;
    logic [5:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;

    logic [31:0] ref_mem [0:AW-1];
    logic [31:0] ref_instr;
    logic [31:0] ref_pc;
    logic [31:0] ref_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_WORDS  (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_fetch  (req_fetch),
        .req_adr    (req_adr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .instr      (instr),
        .old_pc     (old_pc),
        .data       (data),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Unified memory: bench preload port, otherwise written by the DUT.
    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_we) mem[mem_adr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_adr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request, observed from the accept edge until the response retires.
    task automatic run_req(input logic we, input logic fetch, input logic [31:0] adr,
                           input logic [31:0] wdata, input bit junk);
        bit   err;
        int   lat;
        int   we_cnt;
        int   exp_lat;
        logic [5:0] idx;
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_fetch = fetch;
        req_adr   = adr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            req_we    = 1'($urandom_range(0, 1));
            req_fetch = 1'($urandom_range(0, 1));
            req_adr   = 32'($urandom_range(0, 63)) << 2;
            req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        lat    = 0;
        we_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_we) begin
                we_cnt++;
                check("we_adr", mem_adr, adr);
                check("we_data", mem_wdata, wdata);
                check("we_cycle", 32'(c), 32'(W + 1));
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
            check("ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;

        err = (adr[1:0] != 2'b00) || (adr[31:2] >= 30'(AW)) || (we && fetch);
        exp_lat = err ? 1 : W + 2;
        idx = adr[7:2];
        if (!err) begin
            if (we) ref_mem[idx] = wdata;
            else if (fetch) begin
                ref_instr = ref_mem[idx];
                ref_pc    = adr;
            end else ref_data = ref_mem[idx];
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(err));
        check("we_count", 32'(we_cnt), (!err && we) ? 32'd1 : 32'd0);
        check("instr", instr, ref_instr);
        check("old_pc", old_pc, ref_pc);
        check("data", data, ref_data);
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        if (!err && we) check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    // Store whose write cycle is cut short by reset: nothing must land.
    task automatic reset_mid_store();
        logic [31:0] wd;
        wd = ~ref_mem[8];
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_fetch = 1'b0;
        req_adr   = 32'h20;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c < W + 1; c++) @(negedge clk);
        check("rst_we_before", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        ref_instr = 32'd0;
        ref_pc    = 32'd0;
        ref_data  = 32'd0;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_adr", mem_adr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", old_pc, 32'd0);
        check("rst_data", data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_word", mem[8], ref_mem[8]);
        check("rst_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_fetch  = 1'b0;
        req_adr    = 32'd0;
        req_wdata  = 32'd0;
        tb_wr_en   = 1'b0;
        tb_wr_idx  = 6'd0;
        tb_wr_data = 32'd0;
        ref_instr  = 32'd0;
        ref_pc     = 32'd0;
        ref_data   = 32'd0;
        for (int i = 0; i < AW; i++) ref_mem[i] = $urandom;
        ref_mem[2] = 32'h0050_0113;
        for (int i = 0; i < AW; i++) begin
            @(negedge clk);
            tb_wr_en   = 1'b1;
            tb_wr_idx  = 6'(i);
            tb_wr_data = ref_mem[i];
        end
        @(negedge clk);
        tb_wr_en = 1'b0;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_adr", mem_adr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_regs", instr | old_pc | data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_req(1'b0, 1'b1, 32'h0000_0008, 32'd0, 1'b0);
        run_req(1'b1, 1'b0, 32'h0000_003C, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b0, 1'b0, 32'h0000_0006, 32'd0, 1'b0);
        run_req(1'b0, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
        run_req(1'b0, 1'b0, 32'h0000_00FC, 32'd0, 1'b0);
        run_req(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1);
        run_req(1'b0, 1'b0, 32'h0000_003C, 32'd0, 1'b1);
        run_req(1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) a = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
            else a = 32'($urandom_range(0, 63)) << 2;
            run_req(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    a, $urandom, 1'($urandom_range(0, 1)));
        end

        reset_mid_store();
        run_req(1'b0, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
        run_req(1'b0, 1'b1, 32'h0000_003C, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side access sequencer for the multicycle CPU. Sits directly upstream of the unified instruction/data memory.
- Accepts one fetch, load or store request at a time from the datapath/controller over a valid/ready handshake.
- Drives the memory's write-enable, address and write-data, and inserts programmable wait states.
- Captures the memory's combinational read data into the instruction register (with the fetch address as old PC) or into the data register. Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
WAIT_CYCLES, 0, extra memory cycles per access (legal 0..15)
ADDR_WORDS, 64, memory depth in 32-bit words; word index must be < ADDR_WORDS

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_we  in  1  1 = store, 0 = read
req_fetch  in  1  1 = instruction fetch (read into instr/old_pc)
req_adr  in  32  byte address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: access rejected
instr  out  32  instruction register
old_pc  out  32  address of last successful fetch
data  out  32  data register (last successful load)
mem_we  out  1  to memory write enable
mem_adr  out  32  to memory address
mem_wdata  out  32  to memory write data
mem_rdata  in  32  from memory combinational read data

Behaviour:
- Reset (async, reset_n=0): state IDLE. All registers zero: instr, old_pc, data, latched adr/wdata/flags, wait counter. Outputs: req_ready=1, resp_valid=0, resp_err=0, mem_we=0, mem_adr=0, mem_wdata=0.
- mem_we is decoded combinationally from state, so reset mid-access drops it at once; the aborted store never lands.
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: req_ready=0.
  - DONE: req_ready=0.
- IDLE: on req_valid=1 at a rising edge, latch req_adr, req_wdata, req_we and req_fetch.
  - Error if any of: req_adr[1:0]!=0; req_adr[31:2]>=ADDR_WORDS; req_we=1 with req_fetch=1.
  - On error: go to DONE with the err flag set. No memory write; instr, old_pc and data unchanged.
  - Otherwise: go to ACCESS, counter=WAIT_CYCLES.
- ACCESS:
  - mem_adr and mem_wdata come from the latched values; they hold those values in all states until the next accept.
  - If counter!=0: decrement and stay.
  - If counter==0:
    - Store: mem_we=1 for this cycle only, so the write occurs on the following edge.
    - Fetch: instr<=mem_rdata, old_pc<=latched adr.
    - Load: data<=mem_rdata.
    - Then go to DONE.
- DONE: resp_valid=1 and resp_err=err flag for exactly one cycle, then IDLE. A new request can be accepted on the next edge, giving back-to-back throughput of one access per WAIT_CYCLES+3 cycles.
- Latency, counted from the accept edge E:
  - Success: resp_valid is high in the cycle after edge E+WAIT_CYCLES+1.
  - Error: resp_valid is high in the cycle after edge E, in all cases.
- instr and data update only on successful reads, so they are already valid when resp_valid rises.
- req_valid and all request fields are ignored outside IDLE; the requester must hold them until it sees req_ready=1.
- Address arithmetic: the word index is req_adr[31:2], compared unsigned at the full 30 bits; no wrap-around into memory.

Decomposition:
- Shared package (cpu_pkg): state enum {IDLE, ACCESS, DONE}; WORD_BYTES=4; DEFAULT_MEM_WORDS=64.
- Sub-module: addr_check, a combinational misalign/range/fetch-store-conflict detector parameterised by ADDR_WORDS. Reusable by the later data-cache stage.

Test Plan:
- WAIT_CYCLES=0, fetch adr 0x8 with mem_rdata=0x00500113 -> resp_valid one cycle; instr=0x00500113; old_pc=0x8; resp_err=0; mem_we never high.
- WAIT_CYCLES=2, store adr 0x3C wdata 0xDEADBEEF -> mem_we high exactly one cycle, at the 3rd ACCESS cycle, with mem_adr=0x3C and mem_wdata=0xDEADBEEF; resp_valid 3 cycles after accept; memory word 15 reads 0xDEADBEEF.
- Load adr 0x6 -> resp_valid+resp_err the cycle after accept; no write; data unchanged from prior value.
- Load adr 0x100 (word 64, ADDR_WORDS=64) -> resp_err=1. Load adr 0xFC (word 63) -> resp_err=0, data=mem word 63.
- Request with req_we=1 and req_fetch=1 -> resp_err=1. Second request held during ACCESS is not accepted until req_ready returns.
- WAIT_CYCLES=3 store, reset_n pulled low in 2nd ACCESS cycle -> mem_we=0 immediately; target word unchanged; all outputs zero; req_ready=1 after release.
